// File: rtl/gb_freq_sweep.sv
// Channel-1 frequency sweep: periodically shifts the pulse channel period and
// latches a mute flag on overflow, with trigger-time and post-write checks.
module gb_freq_sweep #(
  parameter int unsigned FREQ_W  = 11,
  parameter int unsigned PACE_W  = 3,
  parameter int unsigned SHIFT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_sweep,
  input  logic              trigger,
  input  logic [PACE_W-1:0] sweep_pace,
  input  logic              sweep_decreasing,
  input  logic [SHIFT_W-1:0] num_sweep_shifts,
  input  logic [FREQ_W-1:0] frequency,
  output logic              overflow,
  output logic [FREQ_W-1:0] shadow_frequency,
  output logic              freq_update,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, TRIG_CHK, CALC, POST_CHK} state_t;

  localparam logic [PACE_W:0] TIMER_ONE = {{PACE_W{1'b0}}, 1'b1};

  state_t          r_state;
  logic [PACE_W:0] r_timer;
  logic            r_enabled;
  logic            r_neg_used;

  logic [FREQ_W:0] w_shadow_ext;
  logic [FREQ_W:0] w_delta;
  logic [FREQ_W:0] w_target;
  logic            w_calc_ovf;
  logic [PACE_W:0] w_reload;
  logic            w_pace_zero;
  logic            w_shift_zero;

  always_comb begin
    w_shadow_ext = {1'b0, shadow_frequency};
    w_delta      = w_shadow_ext >> num_sweep_shifts;
    w_target     = sweep_decreasing ? (w_shadow_ext - w_delta) : (w_shadow_ext + w_delta);
    // Subtraction can never go below zero, so only the add path can overflow.
    w_calc_ovf   = !sweep_decreasing && w_target[FREQ_W];
    w_pace_zero  = (sweep_pace == '0);
    w_shift_zero = (num_sweep_shifts == '0);
    w_reload     = '0;
    if (w_pace_zero) w_reload[PACE_W] = 1'b1;
    else             w_reload = {1'b0, sweep_pace};
  end

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_timer          <= '0;
      r_enabled        <= 1'b0;
      r_neg_used       <= 1'b0;
      overflow         <= 1'b0;
      shadow_frequency <= '0;
      freq_update      <= 1'b0;
    end else begin
      freq_update <= 1'b0;
      if (trigger) begin
        shadow_frequency <= frequency;
        r_timer          <= w_reload;
        overflow         <= 1'b0;
        r_neg_used       <= 1'b0;
        r_enabled        <= !w_pace_zero || !w_shift_zero;
        r_state          <= w_shift_zero ? IDLE : TRIG_CHK;
      end else begin
        // Every non-IDLE state evaluates the target, so any of them marks negate use.
        if (r_state != IDLE && sweep_decreasing) r_neg_used <= 1'b1;
        if (r_neg_used && !sweep_decreasing)     overflow   <= 1'b1;
        case (r_state)
          IDLE: begin
            if (clk_sweep) begin
              if (r_timer > TIMER_ONE) begin
                r_timer <= r_timer - TIMER_ONE;
              end else begin
                r_timer <= w_reload;
                if (r_enabled && !w_pace_zero && !overflow) r_state <= CALC;
              end
            end
          end
          TRIG_CHK, POST_CHK: begin
            if (w_calc_ovf) overflow <= 1'b1;
            r_state <= IDLE;
          end
          CALC: begin
            if (w_calc_ovf) begin
              overflow <= 1'b1;
              r_state  <= IDLE;
            end else if (!w_shift_zero) begin
              shadow_frequency <= w_target[FREQ_W-1:0];
              freq_update      <= 1'b1;
              r_state          <= POST_CHK;
            end else begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/gb_freq_sweep.md
Name: gb_freq_sweep

Overview:
- Parametrised successor to the channel-1 frequency sweep unit.
- Sits between the APU register file and the pulse channel's frequency divider. Periodically shifts the channel period up or down and mutes the channel on overflow.
- Adds over the previous generation: configurable widths, a trigger-time overflow check, a post-write second overflow check, negate-mode lockout, a write-back strobe, and asynchronous reset.

Parameters:
FREQ_W, 11, width of frequency / shadow frequency
PACE_W, 3, width of sweep pace field; pace 0 reloads timer with 2^PACE_W
SHIFT_W, 3, width of shift-amount field

Ports:
clk  input  1  system clock (2^22 Hz)
reset  input  1  reset; one clock; reset is asynchronous and active-high
clk_sweep  input  1  single-cycle sweep tick enable (128 Hz rate)
trigger  input  1  single-cycle channel trigger
sweep_pace  input  PACE_W  sweep period in ticks
sweep_decreasing  input  1  1 = subtract, 0 = add
num_sweep_shifts  input  SHIFT_W  right-shift applied to shadow for delta
frequency  input  FREQ_W  frequency value from APU register
overflow  output  1  latched mute flag; channel silent while 1
shadow_frequency  output  FREQ_W  active frequency fed to pulse divider
freq_update  output  1  one-cycle pulse when shadow_frequency is written by a sweep
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, immediate): overflow=0, shadow_frequency=0, freq_update=0, busy=0, timer=0, enabled=0, neg_used=0, state=IDLE.
- Target calc (combinational, FREQ_W+1 bits): delta = shadow>>shifts.
  - Decreasing: target = shadow - delta. This never underflows.
  - Increasing: target = shadow + delta. Overflow iff bit FREQ_W of target = 1.
- Any calc with sweep_decreasing=1 sets neg_used=1.
- Reload value = (pace==0) ? 2^PACE_W : pace. Timer is PACE_W+1 bits wide.
- FSM states: IDLE, TRIG_CHK, CALC, POST_CHK.
- Trigger (highest priority; aborts any state). On the same edge:
  - shadow=frequency, timer=reload, overflow=0, neg_used=0.
  - enabled = (pace!=0) || (shifts!=0).
  - state = (shifts!=0) ? TRIG_CHK : IDLE.
- TRIG_CHK (1 cycle): run calc on shadow; overflow=1 if it overflows; no write-back; go to IDLE.
  - Overflow is visible the cycle after the edge following the trigger.
- IDLE with clk_sweep:
  - If timer>1: timer-1.
  - Otherwise: timer=reload. Go to CALC if enabled && pace!=0 && !overflow; else stay in IDLE.
- CALC (1 cycle):
  - If the calc overflows: overflow=1, go to IDLE.
  - Else if shifts!=0: shadow=target, freq_update=1 for exactly this edge, go to POST_CHK.
  - Else: go to IDLE.
- POST_CHK (1 cycle): run calc on the new shadow; overflow=1 if it overflows; no write-back; go to IDLE.
- Negate lockout: any cycle without trigger where neg_used=1 and sweep_decreasing=0 → overflow=1 on the next edge.
- overflow stays latched until trigger or reset. While overflow=1, ticks still reload/decrement the timer, but shadow never changes.
- clk_sweep arriving while busy=1 is dropped, with no timer change. Tick spacing ≫ 3 cycles, so this is benign.
- Register inputs (pace, shifts, direction) are sampled live each cycle. Mid-period pace changes take effect only at the next reload.
- shadow_frequency changes only on trigger or in CALC.

Test Plan:
- Reset: assert reset asynchronously mid-cycle → all outputs 0 immediately, state IDLE; release → no activity until trigger.
- Increasing chain: freq=0x100, pace=1, shifts=1, dec=0, trigger, then one tick every 20 cycles.
  - Shadow goes 0x180, 0x240, 0x360, 0x510, 0x798, with one freq_update pulse each.
  - POST_CHK after 0x798 (target 0xB64) sets overflow=1. Further ticks leave shadow at 0x798.
- Trigger-time overflow: freq=0x7F0, shifts=1, dec=0, pace=3, trigger → overflow=1 two edges after trigger with no tick; freq_update never pulses.
- Decrease + lockout: freq=0x400, pace=2, shifts=2, dec=1, trigger → first tick no change; second tick shadow=0x300 with freq_update. Then drop dec to 0 → overflow=1 next edge.
- pace=0, shifts=3, freq=0x200: trigger performs the check only (no overflow); 16 ticks → shadow stays 0x200, no freq_update.
- Priority: trigger and clk_sweep on the same edge with timer=1 → trigger values loaded, no CALC. Trigger during POST_CHK → check aborted; overflow=0, shadow=new frequency.
